// File: rtl/seq_div16x8.sv
// seq_div16x8: iterative restoring divider, one quotient bit per clock.
// Signed mode divides magnitudes and applies the signs when the result is written.
module seq_div16x8 #(
  parameter bit SIGNED  = 1'b0,
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] num,
  input  logic [WIDTH_D-1:0] den,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quot,
  output logic [WIDTH_D-1:0] rem,
  output logic               dbz
);
  localparam int CW = $clog2(WIDTH_N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH_N-1:0] r_n;
  logic [WIDTH_D-1:0] r_d;
  logic [WIDTH_D-1:0] r_p;
  logic               r_sq;
  logic               r_sr;
  logic [WIDTH_N-1:0] r_quot;
  logic [WIDTH_D-1:0] r_rem;
  logic               r_dbz;

  logic               w_nneg;
  logic               w_dneg;
  logic [WIDTH_N-1:0] w_nmag;
  logic [WIDTH_D-1:0] w_dmag;
  logic [WIDTH_D:0]   w_ptry;
  logic               w_ge;
  logic [WIDTH_D-1:0] w_pnext;
  logic               w_fin;

  assign w_nneg = SIGNED & num[WIDTH_N-1];
  assign w_dneg = SIGNED & den[WIDTH_D-1];
  assign w_nmag = w_nneg ? -num : num;
  assign w_dmag = w_dneg ? -den : den;

  // Remainder after a subtract is below the divisor, so WIDTH_D bits suffice.
  assign w_ptry  = {r_p, r_n[WIDTH_N-1]};
  assign w_ge    = w_ptry >= {1'b0, r_d};
  assign w_pnext = w_ge ? (w_ptry[WIDTH_D-1:0] - r_d)
                        : w_ptry[WIDTH_D-1:0];
  // Counter underflow past zero marks the finalise cycle.
  assign w_fin   = r_cnt[CW-1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_BUSY;
      S_BUSY:  if (w_fin)     w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_n    <= '0;
      r_d    <= '0;
      r_p    <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_n   <= w_nmag;
            r_d   <= w_dmag;
            r_p   <= '0;
            r_sq  <= w_nneg ^ w_dneg;
            r_sr  <= w_nneg;
            r_cnt <= CW'(WIDTH_N - 1);
          end
        end
        S_BUSY: begin
          if (!w_fin) begin
            r_p   <= w_pnext;
            r_n   <= {r_n[WIDTH_N-2:0], w_ge};
            r_cnt <= r_cnt - CW'(1);
          end else if (r_d == '0) begin
            r_quot <= '1;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
          end else begin
            r_quot <= r_sq ? -r_n : r_n;
            r_rem  <= r_sr ? -r_p : r_p;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign dbz       = r_dbz;
endmodule
